alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the operands and op-code consumed by the execute-stage ALU.
- Takes a raw MIPS instruction plus register-file operands (rs, rt values), decodes it into the ALU's 5-bit opselect, x, y and shamt fields, and registers the result.
- Sits between the register-file read and the EX stage.
- Buffering is a 2-entry valid/ready skid buffer, so back-pressure from EX never creates a combinational path to the fetch side.

Parameters:
- DATA_W, 32: operand width of x/y/rs/rt.
- OPSEL_W, 5: ALU op-select width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous pipeline flush (branch mispredict/exception).
- in_valid  input  1  instruction/operands valid.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  MIPS instruction word.
- in_rs_val  input  DATA_W  value of register rs.
- in_rt_val  input  DATA_W  value of register rt.
- out_valid  output  1  issued op valid.
- out_ready  input  1  EX accepts.
- out_opselect  output  OPSEL_W  ALU op code.
- out_x  output  DATA_W  ALU x operand.
- out_y  output  DATA_W  ALU y operand.
- out_shamt  output  5  ALU shift amount.
- out_dst  output  5  destination register; 0 means no write.
- out_trap_en  output  1  EX must trap when the ALU v output is 1.
- out_illegal  output  1  unrecognised instruction.

Behaviour:
- Reset and flush:
  - Synchronous reset clears both entries.
  - After reset: out_valid=0, in_ready=1, all data outputs 0.
  - Flush clears both entries. The next cycle has out_valid=0 and in_ready=1.
  - Flush overrides acceptance: an input presented in the flush cycle is dropped.
- Fixed opselect codes:
  - ADD=00000, SUB=00001, SLTU=00010, SRAV=00011, SLLV=00100, SLL=00101.
  - GT=00110, SLT=00111, EQ=01000, AND=01001, OR=01010, SRA=01011.
  - NOR=01100, XOR=01101, SRLV=01110, SRL=01111, LE=10000, GE=10001, NE=10010.
- R-type decode (opcode 0), by funct; dst=rd for all:
  - Arithmetic and logic, x=rs, y=rt:
    - 0x20 add → ADD, trap_en=1.
    - 0x21 addu → ADD.
    - 0x22 sub → SUB, trap_en=1.
    - 0x23 subu → SUB.
    - 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR.
    - 0x2A → SLT; 0x2B → SLTU.
  - Constant shifts, x=rt, shamt=instr[10:6]:
    - 0x00 → SLL; 0x02 → SRL; 0x03 → SRA.
  - Variable shifts, x=rt, y=rs:
    - 0x04 → SLLV; 0x06 → SRLV; 0x07 → SRAV.
- I-type decode; imm=instr[15:0], se=sign-extended, ze=zero-extended:
  - ALU immediates, x=rs, dst=rt:
    - 0x08 addi → ADD, y=se, trap_en=1.
    - 0x09 addiu → ADD, y=se.
    - 0x0A → SLT, y=se; 0x0B → SLTU, y=se.
    - 0x0C → AND, y=ze; 0x0D → OR, y=ze; 0x0E → XOR, y=ze.
  - 0x0F lui → SLL, x=ze, shamt=16, dst=rt.
  - Branches, dst=0:
    - 0x04 → EQ, x=rs, y=rt.
    - 0x05 → NE, x=rs, y=rt.
    - 0x06 → LE, x=rs, y=0.
    - 0x07 → GT, x=rs, y=0.
    - 0x01 with rt=0 (bltz) → SLT, x=rs, y=0.
    - 0x01 with rt=1 (bgez) → GE, x=rs, y=0.
  - Memory, ADD with x=rs, y=se:
    - 0x23 lw → dst=rt.
    - 0x2B sw → dst=0.
- Field defaults: unused y=0, unused shamt=0, trap_en=0 unless listed.
- Any other encoding:
  - illegal=1, opselect=ADD.
  - x=y=0, shamt=0, dst=0.
  - Still issued, so EX can raise the exception.
- Skid buffer:
  - Entries are head (drives out_*) and skid. Decode is combinational on in_* and is written into whichever entry is loaded.
  - Accept occurs when in_valid & in_ready & !flush.
  - Consume occurs when out_valid & out_ready.
  - Accept with head empty, or head consumed this cycle while skid is empty: load head.
  - Accept with head held (valid and not consumed): load skid.
  - Consume with skid valid: skid moves to head. A simultaneous accept loads skid.
  - in_ready is registered: next in_ready = !(skid valid next cycle).
- Latency and ordering:
  - Accepted at edge N → visible on out_* after edge N. Latency is 1 cycle.
  - Full throughput of 1 op/cycle when out_ready=1.
  - Strict FIFO order.
  - out_* hold stable while out_valid & !out_ready.
- Simultaneous events: with both entries full and consume+accept in the same cycle, in_ready is already 0, so there is no accept.

Test Plan:
1. add, 0x00221820, rs=5, rt=7 → one cycle later: opselect=00000, x=5, y=7, dst=3, trap_en=1, illegal=0.
2. sllv, 0x00221804, rs=4, rt=1 → opselect=00100, x=1, y=4, dst=3.
3. lui, 0x3C041234 → opselect=00101, x=0x00001234, shamt=16, dst=4. Check: ALU result 0x12340000.
4. Extension rules:
   - andi, 0x3085FFFF → opselect=01001, y=0x0000FFFF, dst=5.
   - addiu, 0x2485FFFF → opselect=00000, y=0xFFFFFFFF, trap_en=0.
   - opcode 0x3F → illegal=1, dst=0.
5. Back-pressure: out_ready=0, issue 3 back-to-back ops A, B, C.
   - A and B accepted; in_ready=0 after B; C held upstream.
   - out_* stay at A while stalled.
   - Raise out_ready → outputs A, B, C in order on consecutive cycles.
6. Flush and reset: with both entries full and in_valid=1, assert flush → next cycle out_valid=0, in_ready=1, input not accepted. Repeat the same setup with reset → identical result plus all data outputs 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Decodes a MIPS instruction and its register-file operands into
//             ALU opselect/x/y/shamt fields. A 2-entry valid/ready skid buffer
//             registers the result, so in_ready has no combinational path
//             from out_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int OPSEL_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [DATA_W-1:0]  in_rs_val,
    input  logic [DATA_W-1:0]  in_rt_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPSEL_W-1:0] out_opselect,
    output logic [DATA_W-1:0]  out_x,
    output logic [DATA_W-1:0]  out_y,
    output logic [4:0]         out_shamt,
    output logic [4:0]         out_dst,
    output logic               out_trap_en,
    output logic               out_illegal
);

    localparam logic [OPSEL_W-1:0] OP_ADD  = OPSEL_W'(5'b00000);
    localparam logic [OPSEL_W-1:0] OP_SUB  = OPSEL_W'(5'b00001);
    localparam logic [OPSEL_W-1:0] OP_SLTU = OPSEL_W'(5'b00010);
    localparam logic [OPSEL_W-1:0] OP_SRAV = OPSEL_W'(5'b00011);
    localparam logic [OPSEL_W-1:0] OP_SLLV = OPSEL_W'(5'b00100);
    localparam logic [OPSEL_W-1:0] OP_SLL  = OPSEL_W'(5'b00101);
    localparam logic [OPSEL_W-1:0] OP_GT   = OPSEL_W'(5'b00110);
    localparam logic [OPSEL_W-1:0] OP_SLT  = OPSEL_W'(5'b00111);
    localparam logic [OPSEL_W-1:0] OP_EQ   = OPSEL_W'(5'b01000);
    localparam logic [OPSEL_W-1:0] OP_AND  = OPSEL_W'(5'b01001);
    localparam logic [OPSEL_W-1:0] OP_OR   = OPSEL_W'(5'b01010);
    localparam logic [OPSEL_W-1:0] OP_SRA  = OPSEL_W'(5'b01011);
    localparam logic [OPSEL_W-1:0] OP_NOR  = OPSEL_W'(5'b01100);
    localparam logic [OPSEL_W-1:0] OP_XOR  = OPSEL_W'(5'b01101);
    localparam logic [OPSEL_W-1:0] OP_SRLV = OPSEL_W'(5'b01110);
    localparam logic [OPSEL_W-1:0] OP_SRL  = OPSEL_W'(5'b01111);
    localparam logic [OPSEL_W-1:0] OP_LE   = OPSEL_W'(5'b10000);
    localparam logic [OPSEL_W-1:0] OP_GE   = OPSEL_W'(5'b10001);
    localparam logic [OPSEL_W-1:0] OP_NE   = OPSEL_W'(5'b10010);

    // One buffer entry: {opselect, x, y, shamt, dst, trap_en, illegal}
    localparam int ENT_W = OPSEL_W + 2 * DATA_W + 12;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt_f, rd_f, sh_f;
    logic [DATA_W-1:0] imm_se, imm_ze;

    assign opcode = in_instr[31:26];
    assign rt_f   = in_instr[20:16];
    assign rd_f   = in_instr[15:11];
    assign sh_f   = in_instr[10:6];
    assign funct  = in_instr[5:0];
    assign imm_se = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    assign imm_ze = {{(DATA_W-16){1'b0}}, in_instr[15:0]};

    logic [OPSEL_W-1:0] dec_op;
    logic [DATA_W-1:0]  dec_x, dec_y;
    logic [4:0]         dec_sh, dec_dst;
    logic               dec_trap, dec_ill;
    logic [ENT_W-1:0]   dec_ent;

    // Combinational instruction decode; unrecognised encodings issue as a blank ADD
    always_comb begin
        dec_op   = OP_ADD;
        dec_x    = '0;
        dec_y    = '0;
        dec_sh   = '0;
        dec_dst  = '0;
        dec_trap = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            6'h00: begin
                dec_dst = rd_f;
                dec_x   = in_rs_val;
                dec_y   = in_rt_val;
                case (funct)
                    6'h20: begin dec_op = OP_ADD; dec_trap = 1'b1; end
                    6'h21: dec_op = OP_ADD;
                    6'h22: begin dec_op = OP_SUB; dec_trap = 1'b1; end
                    6'h23: dec_op = OP_SUB;
                    6'h24: dec_op = OP_AND;
                    6'h25: dec_op = OP_OR;
                    6'h26: dec_op = OP_XOR;
                    6'h27: dec_op = OP_NOR;
                    6'h2A: dec_op = OP_SLT;
                    6'h2B: dec_op = OP_SLTU;
                    6'h00: begin dec_op = OP_SLL; dec_x = in_rt_val; dec_y = '0; dec_sh = sh_f; end
                    6'h02: begin dec_op = OP_SRL; dec_x = in_rt_val; dec_y = '0; dec_sh = sh_f; end
                    6'h03: begin dec_op = OP_SRA; dec_x = in_rt_val; dec_y = '0; dec_sh = sh_f; end
                    6'h04: begin dec_op = OP_SLLV; dec_x = in_rt_val; dec_y = in_rs_val; end
                    6'h06: begin dec_op = OP_SRLV; dec_x = in_rt_val; dec_y = in_rs_val; end
                    6'h07: begin dec_op = OP_SRAV; dec_x = in_rt_val; dec_y = in_rs_val; end
                    default: dec_ill = 1'b1;
                endcase
            end
            6'h08: begin dec_op = OP_ADD;  dec_x = in_rs_val; dec_y = imm_se; dec_dst = rt_f; dec_trap = 1'b1; end
            6'h09: begin dec_op = OP_ADD;  dec_x = in_rs_val; dec_y = imm_se; dec_dst = rt_f; end
            6'h0A: begin dec_op = OP_SLT;  dec_x = in_rs_val; dec_y = imm_se; dec_dst = rt_f; end
            6'h0B: begin dec_op = OP_SLTU; dec_x = in_rs_val; dec_y = imm_se; dec_dst = rt_f; end
            6'h0C: begin dec_op = OP_AND;  dec_x = in_rs_val; dec_y = imm_ze; dec_dst = rt_f; end
            6'h0D: begin dec_op = OP_OR;   dec_x = in_rs_val; dec_y = imm_ze; dec_dst = rt_f; end
            6'h0E: begin dec_op = OP_XOR;  dec_x = in_rs_val; dec_y = imm_ze; dec_dst = rt_f; end
            6'h0F: begin dec_op = OP_SLL;  dec_x = imm_ze; dec_sh = 5'd16; dec_dst = rt_f; end
            6'h04: begin dec_op = OP_EQ;   dec_x = in_rs_val; dec_y = in_rt_val; end
            6'h05: begin dec_op = OP_NE;   dec_x = in_rs_val; dec_y = in_rt_val; end
            6'h06: begin dec_op = OP_LE;   dec_x = in_rs_val; end
            6'h07: begin dec_op = OP_GT;   dec_x = in_rs_val; end
            6'h01: begin
                dec_x = in_rs_val;
                if (rt_f == 5'd0)      dec_op = OP_SLT;
                else if (rt_f == 5'd1) dec_op = OP_GE;
                else                   dec_ill = 1'b1;
            end
            6'h23: begin dec_op = OP_ADD; dec_x = in_rs_val; dec_y = imm_se; dec_dst = rt_f; end
            6'h2B: begin dec_op = OP_ADD; dec_x = in_rs_val; dec_y = imm_se; end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings carry no operands so EX sees a clean exception op
        if (dec_ill) begin
            dec_op   = OP_ADD;
            dec_x    = '0;
            dec_y    = '0;
            dec_sh   = '0;
            dec_dst  = '0;
            dec_trap = 1'b0;
        end
    end

    assign dec_ent = {dec_op, dec_x, dec_y, dec_sh, dec_dst, dec_trap, dec_ill};

    logic             head_v_q, head_v_d, skid_v_q, skid_v_d, ready_q, ready_d;
    logic [ENT_W-1:0] head_q, head_d, skid_q, skid_d;
    logic             accept, consume;

    assign accept  = in_valid & ready_q & ~flush;
    assign consume = head_v_q & out_ready;

    // Skid-buffer next state: drain head, refill from skid, then place any new entry
    always_comb begin
        head_v_d = head_v_q;
        head_d   = head_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (consume) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                head_v_d = 1'b0;
            end
        end
        if (accept) begin
            if (!head_v_q || (consume && !skid_v_q)) begin
                head_v_d = 1'b1;
                head_d   = dec_ent;
            end else begin
                skid_v_d = 1'b1;
                skid_d   = dec_ent;
            end
        end
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
        ready_d = ~skid_v_d;
    end

    // State registers; reset also clears payloads so data outputs read 0
    always_ff @(posedge clk) begin
        if (reset) begin
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            head_q   <= '0;
            skid_q   <= '0;
            ready_q  <= 1'b1;
        end else begin
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            ready_q  <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = head_v_q;
    assign {out_opselect, out_x, out_y, out_shamt, out_dst, out_trap_en, out_illegal} = head_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage using an expected-result
//             queue filled at acceptance and drained on every output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_rs_val, in_rt_val, out_x, out_y;
    logic [4:0]  out_opselect, out_shamt, out_dst;
    logic        out_trap_en, out_illegal;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [80:0] sb[$];

    alu_issue_stage #(.DATA_W(32), .OPSEL_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opselect(out_opselect), .out_x(out_x), .out_y(out_y),
        .out_shamt(out_shamt), .out_dst(out_dst),
        .out_trap_en(out_trap_en), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                       input logic [4:0] sh, input logic [4:0] dst, input logic tr, input logic il);
        return {op, x, y, sh, dst, tr, il};
    endfunction

    function automatic logic [80:0] got();
        return {out_opselect, out_x, out_y, out_shamt, out_dst, out_trap_en, out_illegal};
    endfunction

    // Score the transfer due at the coming edge, then advance to negedge+1
    task automatic tick();
        logic [80:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output got=%h expected=none", got());
            end else begin
                e = sb.pop_front();
                if (got() !== e) $display("FAIL output_data got=%h expected=%h", got(), e);
                else n_pass++;
            end
        end
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input logic [80:0] e);
        int w = 0;
        in_valid = 1'b1; in_instr = ins; in_rs_val = rs; in_rt_val = rt;
        while (in_ready !== 1'b1 && w < 20) begin tick(); w++; end
        if (in_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout instr=%h in_ready=%b expected=1", ins, in_ready);
        end else begin
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic drain();
        int w = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && w < 50) begin tick(); w++; end
        tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL drain_left got=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    task automatic check_idle(input string nm, input logic want_zero);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL %s_out_valid got=%b expected=0", nm, out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s_in_ready got=%b expected=1", nm, in_ready);
        else n_pass++;
        if (want_zero) begin
            n_checks++;
            if (got() !== 81'd0) $display("FAIL %s_data got=%h expected=0", nm, got());
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs_val = '0; in_rt_val = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_idle("reset", 1'b1);
    endtask

    task automatic test_decode();
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        send(32'h00221820, 32'd5,        32'd7,        mk(5'h00, 32'd5,        32'd7,        5'd0,  5'd3, 1'b1, 1'b0)); // add
        send(32'h00221804, 32'd4,        32'd1,        mk(5'h04, 32'd1,        32'd4,        5'd0,  5'd3, 1'b0, 1'b0)); // sllv
        send(32'h3C041234, 32'hDEADBEEF, 32'h11,       mk(5'h05, 32'h1234,     32'd0,        5'd16, 5'd4, 1'b0, 1'b0)); // lui
        send(32'h3085FFFF, 32'h12345678, 32'h0,        mk(5'h09, 32'h12345678, 32'h0000FFFF, 5'd0,  5'd5, 1'b0, 1'b0)); // andi
        send(32'h2485FFFF, 32'h10,       32'h0,        mk(5'h00, 32'h10,       32'hFFFFFFFF, 5'd0,  5'd5, 1'b0, 1'b0)); // addiu
        send(32'hFC000000, 32'd1,        32'd2,        mk(5'h00, 32'd0,        32'd0,        5'd0,  5'd0, 1'b0, 1'b1)); // opcode 3F
        send(32'h00221822, 32'd9,        32'd3,        mk(5'h01, 32'd9,        32'd3,        5'd0,  5'd3, 1'b1, 1'b0)); // sub
        send(32'h00021943, 32'h55,       32'h80000000, mk(5'h0B, 32'h80000000, 32'd0,        5'd5,  5'd3, 1'b0, 1'b0)); // sra
        send(32'h10220000, 32'd6,        32'd6,        mk(5'h08, 32'd6,        32'd6,        5'd0,  5'd0, 1'b0, 1'b0)); // beq
        send(32'h04210000, 32'hFFFFFFFF, 32'h99,       mk(5'h11, 32'hFFFFFFFF, 32'd0,        5'd0,  5'd0, 1'b0, 1'b0)); // bgez
        send(32'h8C45FFFC, 32'h1000,     32'h7,        mk(5'h00, 32'h1000,     32'hFFFFFFFC, 5'd0,  5'd5, 1'b0, 1'b0)); // lw
        send(32'hAC45FFFC, 32'h2000,     32'h7,        mk(5'h00, 32'h2000,     32'hFFFFFFFC, 5'd0,  5'd0, 1'b0, 1'b0)); // sw
        send(32'h00221801, 32'd3,        32'd4,        mk(5'h00, 32'd0,        32'd0,        5'd0,  5'd0, 1'b0, 1'b1)); // bad funct
        send(32'h20858000, 32'd1,        32'd0,        mk(5'h00, 32'd1,        32'hFFFF8000, 5'd0,  5'd5, 1'b1, 1'b0)); // addi
        send(32'h00221827, 32'hF0,       32'h0F,       mk(5'h0C, 32'hF0,       32'h0F,       5'd0,  5'd3, 1'b0, 1'b0)); // nor
        n_checks++;
        if (cyc - c0 != 15) $display("FAIL throughput got=%0d cycles expected=15", cyc - c0);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [80:0] ea;
        ea = mk(5'h0D, 32'd1, 32'd2, 5'd0, 5'd3, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(32'h00221826, 32'd1,  32'd2,  ea);                                                   // xor A
        send(32'h00021902, 32'd0,  32'hF0, mk(5'h0F, 32'hF0, 32'd0, 5'd4, 5'd3, 1'b0, 1'b0));  // srl B
        in_valid = 1'b1; in_instr = 32'h2885FFFF; in_rs_val = 32'd7; in_rt_val = 32'd0;          // slti C
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b expected=0", in_ready);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || got() !== ea) $display("FAIL stall_hold got=%b/%h expected=1/%h", out_valid, got(), ea);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) $display("FAIL b2b_second got=%b/%b expected=1/1", out_valid, in_ready);
        else n_pass++;
        sb.push_back(mk(5'h07, 32'd7, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 1'b0));
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL b2b_third got=%b expected=1", out_valid);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush();
        // flush wins over an accept that would otherwise happen
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00221820; in_rs_val = 32'd1; in_rt_val = 32'd1;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_drop", 1'b0);
        // flush with both entries full and an input waiting
        send(32'h00221826, 32'd1, 32'd2, 81'd0);
        send(32'h00221826, 32'd3, 32'd4, 81'd0);
        in_valid = 1'b1; in_instr = 32'h00221825; in_rs_val = 32'd8; in_rt_val = 32'd9;
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_full", 1'b0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_accept got=%b expected=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        send(32'h00221826, 32'd1, 32'd2, 81'd0);
        send(32'h00221826, 32'd3, 32'd4, 81'd0);
        in_valid = 1'b1; in_instr = 32'h00221825; in_rs_val = 32'd8; in_rt_val = 32'd9;
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check_idle("reset_full", 1'b1);
        // recovery: a fresh op flows after reset
        out_ready = 1'b1;
        send(32'h3C04ABCD, 32'd0, 32'd0, mk(5'h05, 32'hABCD, 32'd0, 5'd16, 5'd4, 1'b0, 1'b0));
        drain();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs_val = '0; in_rt_val = '0;
        @(negedge clk);
        #1;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_full();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
